tt_um_tern_sched: RTL and testbench
===================================

// Module: tt_um_tern_sched
// PURPOSE
//  Top-level sequencer for the ternary weight loader and the MAC array. Starts a job, enables
//  the loader for one full weight load, waits one cycle for the weights to settle, then streams
//  input vectors through the MAC array with valid/ready handshakes. Returns to IDLE after the
//  programmed number of vectors.
// PARAMETERS
//  MAX_IN_LEN   16  max input rows; cfg_in_len range is 0..MAX_IN_LEN-1 (value = count-1)
//  MAX_OUT_LEN  8   max output columns; cfg_out_len range is 0..MAX_OUT_LEN-1 (value = count-1)
//  MAC_LAT      2   cycles from mac_start to valid result on the MAC array (>=1)
//  VEC_BITS     8   width of the vector-count register
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          synchronous reset, active-low
//  start        in   1          job start pulse; sampled only in IDLE
//  cfg_in_len   in   4          input rows - 1; latched on start
//  cfg_out_len  in   3          output columns - 1; latched on start
//  cfg_num_vec  in   VEC_BITS   vectors - 1 to compute; latched on start
//  load_done    in   1          done pulse from the loader
//  load_ena     out  1          loader ena
//  load_param   out  7          loader ui_param = {in_len_q, out_len_q}
//  in_valid     in   1          input vector present
//  in_ready     out  1          vector accepted when in_valid & in_ready
//  mac_start    out  1          1-cycle pulse launching the MAC on the accepted vector
//  out_valid    out  1          result available; held until out_ready
//  out_ready    in   1          consumer accepts result
//  busy         out  1          high in every state except IDLE
//  err          out  1          sticky error flag; cleared on start or reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; load_param=0; counters 0. Reset mid-job aborts immediately.
//  States and transitions:
//  IDLE -> LOAD on start. Latch cfg_*, clear err. load_ena is 0 in IDLE, so the loader sees a
//    rising ena edge and resets its row count.
//  LOAD: load_ena=1. On load_done, go to LOAD_LSB.
//  LOAD_LSB: load_ena=1 for exactly one cycle, which writes the final row. Then go to SETTLE.
//  SETTLE: load_ena=0 for one cycle while the weights register. Then go to ACCEPT.
//  ACCEPT: in_ready=1. On handshake: mac_start=1 that cycle; go to COMPUTE; start lat_cnt.
//  COMPUTE: in_ready=0. Go to OUTPUT after MAC_LAT cycles.
//  OUTPUT: out_valid=1 until out_ready. On handshake:
//    if vec_cnt==num_vec_q: go to IDLE; else vec_cnt+1, go to ACCEPT.
//    out_valid never drops without a handshake.
//  Timing:
//   - Load phase lasts 2*(cfg_out_len+1) enabled cycles, plus 1 SETTLE cycle.
//   - Minimum per-vector period is MAC_LAT+2 cycles.
//  Boundaries:
//   - start is ignored while busy.
//   - load_done outside LOAD is ignored.
//   - out_ready without out_valid has no effect.
//   - in_valid may be held across IDLE; no acceptance happens outside ACCEPT.
//   - vec_cnt compares for equality, so cfg_num_vec=all-ones gives 2^VEC_BITS vectors (no wrap).
//   - cfg_out_len=0 gives a 2-cycle load.
// CONFIGURATION
//  TERN_SCHED_WDOG_EN defined:
//   - A LOAD-state counter runs.
//   - If load_done is not seen within 2*MAX_OUT_LEN+2 cycles of entering LOAD: set err, drop
//     load_ena, go to IDLE.
//  TERN_SCHED_WDOG_EN undefined: no counter; LOAD waits for load_done indefinitely; err stays 0.
// TESTING
//  1. cfg_out_len=3, cfg_in_len=15, cfg_num_vec=0, start; loader model pulses done on its 7th
//     ena cycle -> load_ena high 8 cycles, 1 SETTLE cycle, then in_ready; one vector ->
//     mac_start, out_valid after 2 cycles, then IDLE and busy=0.
//  2. cfg_num_vec=4, in_valid always 1, out_ready always 1 -> exactly 5 mac_start pulses,
//     spaced 4 cycles apart (MAC_LAT=2), then IDLE.
//  3. Hold out_ready=0 for 10 cycles in OUTPUT -> out_valid stays 1, in_ready stays 0,
//     no extra mac_start.
//  4. Pulse start during COMPUTE, and pulse load_done during ACCEPT -> no state or output change.
//  5. Assert rst_n=0 for 1 cycle mid-LOAD -> next cycle all outputs 0, state IDLE;
//     a fresh start reloads fully.
//  6. With TERN_SCHED_WDOG_EN, never pulse load_done, cfg_out_len=7 -> after 18 cycles err=1,
//     load_ena=0, busy=0. Without the macro -> still in LOAD after 100 cycles, err=0.

Source files
------------

// File: rtl/tt_um_tern_sched.sv
// ============================================================================
// Module  : tt_um_tern_sched
// Brief   : Job sequencer for the ternary weight loader and MAC array.
//           Optional load watchdog enabled by defining TERN_SCHED_WDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_tern_sched #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int MAC_LAT     = 2,
  parameter int VEC_BITS    = 8
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               start,
  input  logic [$clog2(MAX_IN_LEN)-1:0]                      cfg_in_len,
  input  logic [$clog2(MAX_OUT_LEN)-1:0]                     cfg_out_len,
  input  logic [VEC_BITS-1:0]                                cfg_num_vec,
  input  logic                                               load_done,
  output logic                                               load_ena,
  output logic [$clog2(MAX_IN_LEN)+$clog2(MAX_OUT_LEN)-1:0]  load_param,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  output logic                                               mac_start,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic                                               busy,
  output logic                                               err
);

  localparam int IN_W  = $clog2(MAX_IN_LEN);
  localparam int OUT_W = $clog2(MAX_OUT_LEN);
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_LOAD_LSB = 3'd2,
    S_SETTLE   = 3'd3,
    S_ACCEPT   = 3'd4,
    S_COMPUTE  = 3'd5,
    S_OUTPUT   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IN_W-1:0]     r_in_len;
  logic [OUT_W-1:0]    r_out_len;
  logic [VEC_BITS-1:0] r_num_vec;
  logic [VEC_BITS-1:0] r_vec_cnt;
  logic [LAT_W-1:0]    r_lat_cnt;

  logic w_start_job;
  logic w_accept;
  logic w_deliver;
  logic w_last_vec;
  logic w_lat_done;
  logic w_wdog_trip;

  assign w_start_job = (r_state == S_IDLE) && start;
  assign w_accept    = (r_state == S_ACCEPT) && in_valid;
  assign w_deliver   = (r_state == S_OUTPUT) && out_ready;
  // Equality compare lets an all-ones count run the full 2^VEC_BITS vectors.
  assign w_last_vec  = (r_vec_cnt == r_num_vec);
  assign w_lat_done  = (r_lat_cnt == LAT_W'(MAC_LAT - 1));
  assign load_param  = {r_in_len, r_out_len};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_len  <= '0;
      r_out_len <= '0;
      r_num_vec <= '0;
      r_vec_cnt <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_job) begin
        r_in_len  <= cfg_in_len;
        r_out_len <= cfg_out_len;
        r_num_vec <= cfg_num_vec;
        r_vec_cnt <= '0;
      end
      if (w_accept) begin
        r_lat_cnt <= '0;
      end else if (r_state == S_COMPUTE) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
      if (w_deliver && !w_last_vec) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
      end
    end
  end

`ifdef TERN_SCHED_WDOG_EN
  localparam int WDOG_LIM = 2 * MAX_OUT_LEN + 2;
  localparam int WD_W     = $clog2(WDOG_LIM + 1);

  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_err;

  assign w_wdog_trip = (r_state == S_LOAD) && !load_done &&
                       (r_wdog_cnt == WD_W'(WDOG_LIM - 1));
  assign err = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start_job) begin
        r_wdog_cnt <= '0;
        r_err      <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
      if (w_wdog_trip) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_trip = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    load_ena    = 1'b0;
    in_ready    = 1'b0;
    mac_start   = 1'b0;
    out_valid   = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_ena = 1'b1;
        if (load_done)        w_state_nxt = S_LOAD_LSB;
        else if (w_wdog_trip) w_state_nxt = S_IDLE;
      end
      // Loader writes its final row on this extra enabled cycle.
      S_LOAD_LSB: begin
        load_ena    = 1'b1;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_state_nxt = S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mac_start   = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_lat_done) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = w_last_vec ? S_IDLE : S_ACCEPT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_um_tern_sched.sv
// ============================================================================
// Module  : tb_tt_um_tern_sched
// Brief   : Directed self-checking bench for tt_um_tern_sched with a loader model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_tern_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] cfg_in_len;
  logic [2:0] cfg_out_len;
  logic [7:0] cfg_num_vec;
  logic       load_done;
  logic       load_ena;
  logic [6:0] load_param;
  logic       in_valid;
  logic       in_ready;
  logic       mac_start;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;

  logic ld_auto;
  logic ld_force;
  int   ld_target;
  int   ld_cnt = 0;
  int   cyc = 0;
  int   ena_total = 0;
  int   mac_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   base;
  int   mbase;

  always #5 clk = ~clk;

  tt_um_tern_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_in_len  (cfg_in_len),
    .cfg_out_len (cfg_out_len),
    .cfg_num_vec (cfg_num_vec),
    .load_done   (load_done),
    .load_ena    (load_ena),
    .load_param  (load_param),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mac_start   (mac_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  // Loader model: restarts its row count on each ena rising edge and
  // pulses done on its ld_target-th enabled cycle.
  assign load_done = ld_force | (ld_auto & load_ena & (ld_cnt == ld_target - 1));

  always @(posedge clk) begin
    ld_cnt    <= load_ena ? ld_cnt + 1 : 0;
    cyc       <= cyc + 1;
    ena_total <= ena_total + int'(load_ena);
    if (mac_start) mac_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] il, input logic [2:0] ol, input logic [7:0] nv);
    cfg_in_len  = il;
    cfg_out_len = ol;
    cfg_num_vec = nv;
    start       = 1'b1;
    tick(1);
    start       = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_in_len = '0; cfg_out_len = '0; cfg_num_vec = '0;
    in_valid = 1'b0; out_ready = 1'b0; ld_auto = 1'b0; ld_force = 1'b0; ld_target = 1;
    tick(2);
    check_eq("reset_outs", {load_ena, in_ready, mac_start, out_valid, busy, err, load_param}, 13'h0);
    rst_n = 1'b1;
    tick(1);

    // Single vector, 4-column load: 8 enabled cycles, 1 settle cycle.
    ld_auto = 1'b1; ld_target = 7; base = ena_total;
    kick(4'd15, 3'd3, 8'd0);
    check_eq("t1_param", load_param, 7'h7B);
    check_eq("t1_load", {busy, load_ena, in_ready}, 3'b110);
    tick(7);
    check_eq("t1_lsb", load_ena, 1'b1);
    tick(1);
    check_eq("t1_settle", {load_ena, in_ready, busy}, 3'b001);
    check_eq("t1_ena_cycles", ena_total - base, 8);
    tick(1);
    check_eq("t1_accept", {in_ready, mac_start}, 2'b10);
    in_valid = 1'b1; #1;
    check_eq("t1_mac", mac_start, 1'b1);
    tick(1); in_valid = 1'b0;
    check_eq("t1_compute1", {in_ready, out_valid, mac_start}, 3'b000);
    tick(1);
    check_eq("t1_compute2", out_valid, 1'b0);
    tick(1);
    check_eq("t1_output", out_valid, 1'b1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check_eq("t1_idle", {busy, out_valid, err}, 3'b000);

    // Five back-to-back vectors with a 2-cycle load.
    in_valid = 1'b1; out_ready = 1'b1;
    tick(1);
    check_eq("t2_idle_hold", {in_ready, mac_start}, 2'b00);
    ld_target = 1; base = ena_total; mbase = mac_q.size();
    kick(4'd2, 3'd0, 8'd4);
    for (int i = 0; i < 100 && busy; i++) tick(1);
    check_eq("t2_done", busy, 1'b0);
    check_eq("t2_macs", mac_q.size() - mbase, 5);
    check_eq("t2_ena_cycles", ena_total - base, 2);
    for (int k = 1; k < 5 && k < mac_q.size() - mbase; k++)
      check_eq("t2_spacing", mac_q[mbase+k] - mac_q[mbase+k-1], 4);
    in_valid = 1'b0; out_ready = 1'b0;

    // Consumer stalls in OUTPUT for 10 cycles.
    in_valid = 1'b1;
    kick(4'd1, 3'd0, 8'd0);
    for (int i = 0; i < 20 && !out_valid; i++) tick(1);
    check_eq("t3_reach_out", out_valid, 1'b1);
    mbase = mac_q.size();
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("t3_hold", {out_valid, in_ready, mac_start}, 3'b100);
    end
    check_eq("t3_nomac", mac_q.size() - mbase, 0);
    out_ready = 1'b1; tick(1); out_ready = 1'b0; in_valid = 1'b0;
    check_eq("t3_idle", busy, 1'b0);

    // Stray load_done in ACCEPT, stray start in COMPUTE, stray out_ready in ACCEPT.
    kick(4'd5, 3'd0, 8'd1);
    for (int i = 0; i < 20 && !in_ready; i++) tick(1);
    check_eq("t4_reach_acc", in_ready, 1'b1);
    ld_force = 1'b1; #1;
    check_eq("t4_done_acc", {load_ena, in_ready, out_valid, busy}, 4'b0101);
    tick(1); ld_force = 1'b0;
    check_eq("t4_acc_hold", {load_ena, in_ready}, 2'b01);
    in_valid = 1'b1; tick(1); in_valid = 1'b0;
    kick(4'd0, 3'd7, 8'd9);
    check_eq("t4_param_kept", load_param, 7'h28);
    check_eq("t4_start_busy", {load_ena, in_ready, out_valid, busy}, 4'b0001);
    tick(1);
    check_eq("t4_output", out_valid, 1'b1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check_eq("t4_next_vec", {in_ready, busy}, 2'b11);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check_eq("t4_stray_rdy", {in_ready, out_valid, busy}, 3'b101);
    in_valid = 1'b1; tick(1); in_valid = 1'b0;
    tick(2);
    check_eq("t4_output2", out_valid, 1'b1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check_eq("t4_idle", busy, 1'b0);

    // Reset mid-LOAD, then a full reload.
    ld_target = 7;
    kick(4'd15, 3'd3, 8'd0);
    tick(3);
    rst_n = 1'b0; tick(1);
    check_eq("t5_reset", {load_ena, in_ready, mac_start, out_valid, busy, err, load_param}, 13'h0);
    rst_n = 1'b1; base = ena_total;
    kick(4'd15, 3'd3, 8'd0);
    for (int i = 0; i < 30 && !in_ready; i++) tick(1);
    check_eq("t5_reach_acc", in_ready, 1'b1);
    check_eq("t5_reload", ena_total - base, 8);
    pulse_reset();

    // Loader never answers.
    ld_auto = 1'b0;
    kick(4'd0, 3'd7, 8'd0);
`ifdef TERN_SCHED_WDOG_EN
    tick(17);
    check_eq("t6_pre_trip", {load_ena, err, busy}, 3'b101);
    tick(1);
    check_eq("t6_trip", {err, load_ena, busy}, 3'b100);
    kick(4'd0, 3'd7, 8'd0);
    check_eq("t6_err_clear", {err, busy}, 2'b01);
`else
    tick(100);
    check_eq("t6_no_wdog", {load_ena, busy, err}, 3'b110);
`endif
    pulse_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
